// File: rtl/shift_register.sv
// ============================================================================
//  Module      : shift_register
//  Description : WIDTH-bit universal shift register (hold, shift right,
//                shift left, parallel load) with a shared serial input.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_register #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       s,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    localparam logic [1:0] c_HOLD  = 2'b00;
    localparam logic [1:0] c_RIGHT = 2'b01;
    localparam logic [1:0] c_LEFT  = 2'b10;
    localparam logic [1:0] c_LOAD  = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_q;
        unique case (s)
            c_HOLD:  w_next = r_q;
            c_RIGHT: w_next = {serial_in, r_q[WIDTH-1:1]};
            c_LEFT:  w_next = {r_q[WIDTH-2:0], serial_in};
            c_LOAD:  w_next = in;
            // Unknown mode codes fall back to hold.
            default: w_next = r_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_register.sv
// ============================================================================
//  Module      : tb_shift_register
//  Description : Directed self-checking bench for shift_register (WIDTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_register;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in;
    logic [1:0]       s;
    logic             serial_in;
    logic [WIDTH-1:0] q;

    int r_checks;
    int r_fails;

    shift_register #(
        .WIDTH(WIDTH)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .s         (s),
        .serial_in (serial_in),
        .q         (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                         input logic [WIDTH-1:0] expected);
        r_checks = r_checks + 1;
        if (observed !== expected) begin
            r_fails = r_fails + 1;
            $display("FAIL %s: q=%b expected %b at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic [1:0] mode, input logic sin, input logic [WIDTH-1:0] din);
        @(negedge clk);
        s         = mode;
        serial_in = sin;
        in        = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        r_checks  = 0;
        r_fails   = 0;
        rst_n     = 1'b1;
        s         = 2'b00;
        in        = '0;
        serial_in = 1'b0;

        // Asynchronous reset mid-cycle, released mid-cycle
        #3 rst_n = 1'b0;
        #1 check("reset_async", q, 4'b0000);
        #9 rst_n = 1'b1;
        #1 check("reset_release", q, 4'b0000);
        @(posedge clk); #1;
        check("reset_first_edge_hold", q, 4'b0000);

        // Parallel load, then hold with distracting inputs
        step(2'b11, 1'b0, 4'b1010); check("load_1010", q, 4'b1010);
        step(2'b00, 1'b1, 4'b0101); check("hold_1", q, 4'b1010);
        step(2'b00, 1'b1, 4'b0101); check("hold_2", q, 4'b1010);

        // Shift right with serial_in=1
        step(2'b01, 1'b1, 4'b0000); check("shr_1", q, 4'b1101);
        step(2'b01, 1'b1, 4'b0000); check("shr_2", q, 4'b1110);
        step(2'b00, 1'b0, 4'b0000); check("shr_hold", q, 4'b1110);

        // Shift left, serial_in 1 then 0
        step(2'b10, 1'b1, 4'b0000); check("shl_1", q, 4'b1101);
        step(2'b10, 1'b0, 4'b0000); check("shl_2", q, 4'b1010);
        step(2'b10, 1'b0, 4'b0000); check("shl_3", q, 4'b0100);
        step(2'b10, 1'b0, 4'b0000); check("shl_4", q, 4'b1000);
        step(2'b10, 1'b0, 4'b0000); check("shl_5", q, 4'b0000);
        step(2'b10, 1'b0, 4'b0000); check("shl_6", q, 4'b0000);

        // Walk a single 1 rightward through every position
        step(2'b01, 1'b1, 4'b1111); check("walk_r_0", q, 4'b1000);
        step(2'b01, 1'b0, 4'b1111); check("walk_r_1", q, 4'b0100);
        step(2'b01, 1'b0, 4'b1111); check("walk_r_2", q, 4'b0010);
        step(2'b01, 1'b0, 4'b1111); check("walk_r_3", q, 4'b0001);
        step(2'b01, 1'b0, 4'b1111); check("walk_r_4", q, 4'b0000);

        // Walk a single 1 leftward through every position
        step(2'b10, 1'b1, 4'b1111); check("walk_l_0", q, 4'b0001);
        step(2'b10, 1'b0, 4'b1111); check("walk_l_1", q, 4'b0010);
        step(2'b10, 1'b0, 4'b1111); check("walk_l_2", q, 4'b0100);
        step(2'b10, 1'b0, 4'b1111); check("walk_l_3", q, 4'b1000);
        step(2'b10, 1'b0, 4'b1111); check("walk_l_4", q, 4'b0000);

        // Load ignores serial_in; back-to-back mode changes
        step(2'b11, 1'b1, 4'b0110); check("load_0110", q, 4'b0110);
        step(2'b01, 1'b0, 4'b1111); check("b2b_shr", q, 4'b0011);
        step(2'b10, 1'b1, 4'b0000); check("b2b_shl", q, 4'b0111);
        step(2'b11, 1'b0, 4'b1001); check("b2b_load", q, 4'b1001);
        step(2'b01, 1'b1, 4'b0000); check("pre_reset_shr", q, 4'b1100);

        // Reset asserted between edges while shifting right
        #2 rst_n = 1'b0;
        #1 check("reset_mid_shift", q, 4'b0000);
        @(posedge clk); #1;
        check("reset_held_over_edge", q, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("resume_after_reset", q, 4'b1000);
        step(2'b01, 1'b1, 4'b0000); check("resume_shr_2", q, 4'b1100);

        $display("End of test - %0d assertions evaluated, %0d failures", r_checks, r_fails);
        $finish;
    end

endmodule

`default_nettype wire
